// File: rtl/ysyx_2022040010_mem_pkg.sv
// Shared widths, size codes, FSM encoding and the EX->MEM bus layout for the MEM stage.
// Consumers: ysyx_2022040010_mem, ysyx_2022040010_lsu_align and the testbench.
package ysyx_2022040010_mem_pkg;

    localparam int EX_TO_MEM_WD = 203;
    localparam int MEM_TO_WB_WD = 134;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;
    localparam logic [1:0] MEM_SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_e;

    // Field order matches the EX->MEM bus, MSB first.
    typedef struct packed {
        logic [63:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [63:0] alu_result;
        logic        mem_ren;
        logic        mem_wen;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic [63:0] mem_wdata;
    } ex_to_mem_t;

    // Low address bits that must be zero for an access of the given size.
    function automatic logic [2:0] size_align_mask(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: size_align_mask = 3'b000;
            MEM_SIZE_H: size_align_mask = 3'b001;
            MEM_SIZE_W: size_align_mask = 3'b011;
            default:    size_align_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_2022040010_lsu_align.sv
// Combinational byte-lane placement for stores and extraction/extension for loads.
module ysyx_2022040010_lsu_align
    import ysyx_2022040010_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [2:0]  addr_lo,
    input  logic [63:0] store_data,
    input  logic [63:0] rdata,
    output logic [63:0] wdata,
    output logic [7:0]  wmask,
    output logic [63:0] load_data
);

    logic [7:0]  base_mask;
    logic [63:0] rdata_shifted;
    logic [7:0]  lane_byte [8];

    always_comb begin
        case (size)
            MEM_SIZE_B: base_mask = 8'h01;
            MEM_SIZE_H: base_mask = 8'h03;
            MEM_SIZE_W: base_mask = 8'h0F;
            default:    base_mask = 8'hFF;
        endcase
    end

    // Lanes past byte 7 fall off the top; no wrap-around.
    assign wmask = base_mask << addr_lo;
    assign wdata = store_data << {addr_lo, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_byte[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        rdata_shifted = '0;
        for (int b = 0; b < 8; b++) begin
            if (32'(b) + 32'(addr_lo) < 32'd8)
                rdata_shifted[8*b +: 8] = lane_byte[b + 32'(addr_lo)];
        end
    end

    always_comb begin
        case (size)
            MEM_SIZE_B: load_data = is_unsigned ? {56'b0, rdata_shifted[7:0]}
                                                : {{56{rdata_shifted[7]}}, rdata_shifted[7:0]};
            MEM_SIZE_H: load_data = is_unsigned ? {48'b0, rdata_shifted[15:0]}
                                                : {{48{rdata_shifted[15]}}, rdata_shifted[15:0]};
            MEM_SIZE_W: load_data = is_unsigned ? {32'b0, rdata_shifted[31:0]}
                                                : {{32{rdata_shifted[31]}}, rdata_shifted[31:0]};
            default:    load_data = rdata_shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_2022040010_mem.sv
// RV64 MEM stage: latches one EX instruction, runs its dmem transaction, emits a one-cycle WB result.
// Optional YSYX_2022040010_MEM_MISALIGN_CHECK_EN turns misaligned accesses into flagged no-ops.
module ysyx_2022040010_mem
    import ysyx_2022040010_mem_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_to_mem_valid,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic                    mem_allowin,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [63:0]             dmem_addr,
    output logic [63:0]             dmem_wdata,
    output logic [7:0]              dmem_wmask,
    input  logic                    dmem_gnt,
    input  logic                    dmem_rvalid,
    input  logic [63:0]             dmem_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic                    misalign_err
);

    mem_state_e  state_reg, state_next;
    ex_to_mem_t  stage_reg;
    ex_to_mem_t  ex_in;
    logic [63:0] rf_wdata_reg;
    logic        rf_we_reg;
    logic        accept;
    logic        in_is_mem;
    logic        in_misalign;
    logic [63:0] load_data;

    assign ex_in       = ex_to_mem_bus;
    assign mem_allowin = (state_reg == MEM_IDLE) || (state_reg == MEM_DONE);
    assign accept      = ex_to_mem_valid && mem_allowin;
    assign in_is_mem   = ex_in.mem_ren || ex_in.mem_wen;

`ifdef YSYX_2022040010_MEM_MISALIGN_CHECK_EN
    logic misalign_reg;

    assign in_misalign = in_is_mem &&
                         ((ex_in.alu_result[2:0] & size_align_mask(ex_in.mem_size)) != 3'b000);

    always_ff @(posedge clk) begin
        if (!rst)
            misalign_reg <= 1'b0;
        else if (accept)
            misalign_reg <= in_misalign;
    end

    assign misalign_err = (state_reg == MEM_DONE) && misalign_reg;
`else
    assign in_misalign  = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MEM_IDLE, MEM_DONE: begin
                if (accept)
                    state_next = (in_is_mem && !in_misalign) ? MEM_REQ : MEM_DONE;
                else
                    state_next = MEM_IDLE;
            end
            MEM_REQ: begin
                if (dmem_gnt)
                    state_next = stage_reg.mem_wen ? MEM_DONE : MEM_WAIT;
            end
            MEM_WAIT: begin
                if (dmem_rvalid)
                    state_next = MEM_DONE;
            end
            default: state_next = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= MEM_IDLE;
            stage_reg    <= '0;
            rf_wdata_reg <= '0;
            rf_we_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                stage_reg    <= ex_in;
                rf_we_reg    <= ex_in.rf_we && !in_misalign;
                rf_wdata_reg <= ex_in.alu_result;
            end else if (state_reg == MEM_WAIT && dmem_rvalid) begin
                rf_wdata_reg <= load_data;
            end
        end
    end

    ysyx_2022040010_lsu_align u_align (
        .size        (stage_reg.mem_size),
        .is_unsigned (stage_reg.mem_unsigned),
        .addr_lo     (stage_reg.alu_result[2:0]),
        .store_data  (stage_reg.mem_wdata),
        .rdata       (dmem_rdata),
        .wdata       (dmem_wdata),
        .wmask       (dmem_wmask),
        .load_data   (load_data)
    );

    assign dmem_req  = (state_reg == MEM_REQ);
    assign dmem_we   = dmem_req && stage_reg.mem_wen;
    assign dmem_addr = {stage_reg.alu_result[63:3], 3'b000};

    assign mem_to_wb_bus = (state_reg == MEM_DONE)
                         ? {stage_reg.pc, rf_we_reg, stage_reg.rf_waddr, rf_wdata_reg}
                         : '0;

endmodule
